// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit: FSM encoding, default vectors
// and the next-PC source tag reported by the selector.
package rv32i_pc_pkg;
  localparam logic [1:0]  ST_BOOT = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_HALT = 2'd2;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SEL_SEQ, SEL_HOLD, SEL_TRAP, SEL_REDIR, SEL_MISAL, SEL_MRET, SEL_HALT, SEL_RESUME
  } sel_e;
endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the PC unit (slave) and the pipeline driving it (master).
interface pc_unit_if #(parameter int XLEN = 32);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic            mret;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_inc;
  logic            pc_valid;
  logic [XLEN-1:0] epc;
  logic            misaligned;
  logic [XLEN-1:0] bad_addr;
  logic [1:0]      state;

  modport master (
    output stall, redirect_valid, redirect_target, trap_req, mret, halt_req, resume,
    input  pc, pc_plus_inc, pc_valid, epc, misaligned, bad_addr, state
  );
  modport slave (
    input  stall, redirect_valid, redirect_target, trap_req, mret, halt_req, resume,
    output pc, pc_plus_inc, pc_valid, epc, misaligned, bad_addr, state
  );
endinterface

// File: rtl/pc_unit_next_sel.sv
// Combinational next-PC / next-state selection for RUN and HALT; BOOT is owned by pc_unit.
import rv32i_pc_pkg::*;

module pc_next_sel #(
  parameter int              XLEN        = 32,
  parameter int              INC         = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR)
) (
  input  logic [1:0]      state,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            resume,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] pc_plus_inc,
  output logic [XLEN-1:0] pc_nxt,
  output logic [1:0]      state_nxt,
  output logic            epc_we,
  output logic            misal,
  output sel_e            sel
);
  logic unaligned;
  // INC is a power of two, so alignment is a low-bit mask test
  assign unaligned = (redirect_target & XLEN'(INC - 1)) != '0;

  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    epc_we    = 1'b0;
    misal     = 1'b0;
    sel       = SEL_HOLD;
    case (state)
      ST_RUN: begin
        if (trap_req) begin
          sel = SEL_TRAP;  pc_nxt = TRAP_VECTOR; epc_we = 1'b1;
        end else if (redirect_valid && unaligned) begin
          sel = SEL_MISAL; pc_nxt = TRAP_VECTOR; epc_we = 1'b1; misal = 1'b1;
        end else if (redirect_valid) begin
          sel = SEL_REDIR; pc_nxt = redirect_target;
        end else if (mret) begin
          sel = SEL_MRET;  pc_nxt = epc;
        end else if (halt_req) begin
          sel = SEL_HALT;  state_nxt = ST_HALT;
        end else if (!stall) begin
          sel = SEL_SEQ;   pc_nxt = pc_plus_inc;
        end
      end
      ST_HALT: begin
        if (resume) begin
          sel = SEL_RESUME; state_nxt = ST_RUN;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT control, trap entry/return and misaligned
// redirect detection. Registers and FSM live here; priority logic in pc_next_sel.
import rv32i_pc_pkg::*;

module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              INC          = 4
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);
  logic [XLEN-1:0] pc_q, epc_q, bad_q, pc_nxt, pc_inc;
  logic [1:0]      state_q, state_nxt;
  logic            mis_q, epc_we, misal, booted;
  sel_e            sel;

  assign pc_inc = pc_q + XLEN'(INC);

  pc_next_sel #(.XLEN(XLEN), .INC(INC), .TRAP_VECTOR(TRAP_VECTOR)) u_sel (
    .state          (state_q),
    .stall          (bus.stall),
    .redirect_valid (bus.redirect_valid),
    .redirect_target(bus.redirect_target),
    .trap_req       (bus.trap_req),
    .mret           (bus.mret),
    .halt_req       (bus.halt_req),
    .resume         (bus.resume),
    .pc             (pc_q),
    .epc            (epc_q),
    .pc_plus_inc    (pc_inc),
    .pc_nxt         (pc_nxt),
    .state_nxt      (state_nxt),
    .epc_we         (epc_we),
    .misal          (misal),
    .sel            (sel)
  );

  // booted marks the edge that samples reset release; BOOT then lasts one full cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      booted  <= 1'b0;
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      bad_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      booted <= 1'b1;
      mis_q  <= misal;
      if (state_q == ST_BOOT) begin
        if (booted) state_q <= ST_RUN;
      end else begin
        state_q <= state_nxt;
        pc_q    <= pc_nxt;
        if (epc_we) epc_q <= pc_q;
        if (misal)  bad_q <= bus.redirect_target;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus_inc = pc_inc;
  assign bus.pc_valid    = (state_q == ST_RUN);
  assign bus.epc         = epc_q;
  assign bus.misaligned  = mis_q;
  assign bus.bad_addr    = bad_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot sequence, redirects, traps, mret, wrap and halt.
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  pc_unit_if bus ();
  pc_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = '0;
    bus.trap_req = 0; bus.mret = 0; bus.halt_req = 0; bus.resume = 0;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_valid", 32'(bus.pc_valid), 32'd0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_bad", bus.bad_addr, 32'h0);
    chk("rst_mis", 32'(bus.misaligned), 32'd0);
    repeat (3) step();
    reset = 1'b1;

    step();
    chk("boot_state", 32'(bus.state), 32'd0);
    chk("boot_pc", bus.pc, 32'h0);
    step();
    chk("run_state", 32'(bus.state), 32'd1);
    chk("run_valid", 32'(bus.pc_valid), 32'd1);
    chk("seq0", bus.pc, 32'h0);
    step(); chk("seq4", bus.pc, 32'h4);
    step(); chk("seq8", bus.pc, 32'h8);
    step(); chk("seq12", bus.pc, 32'hC);
    step(); chk("seq16", bus.pc, 32'h10);

    bus.stall = 1; bus.redirect_valid = 1; bus.redirect_target = 32'h40;
    step(); chk("redir_over_stall", bus.pc, 32'h40);
    bus.redirect_valid = 0;
    step(); chk("stall1", bus.pc, 32'h40);
    step(); chk("stall2", bus.pc, 32'h40);
    bus.stall = 0;

    bus.redirect_valid = 1; bus.redirect_target = 32'h20;
    step(); chk("redir20", bus.pc, 32'h20);
    bus.redirect_target = 32'h42;
    step();
    chk("mis_pc", bus.pc, 32'h100);
    chk("mis_pulse", 32'(bus.misaligned), 32'd1);
    chk("mis_bad", bus.bad_addr, 32'h42);
    chk("mis_epc", bus.epc, 32'h20);
    clr(); bus.mret = 1;
    step();
    chk("mret_pc", bus.pc, 32'h20);
    chk("mis_one_cycle", 32'(bus.misaligned), 32'd0);
    chk("mret_epc", bus.epc, 32'h20);

    clr(); bus.redirect_valid = 1; bus.redirect_target = 32'h30;
    step(); chk("redir30", bus.pc, 32'h30);
    bus.trap_req = 1; bus.redirect_target = 32'h80;
    step();
    chk("trap_pc", bus.pc, 32'h100);
    chk("trap_epc", bus.epc, 32'h30);
    chk("trap_mis", 32'(bus.misaligned), 32'd0);
    chk("trap_bad_kept", bus.bad_addr, 32'h42);

    clr(); bus.redirect_valid = 1; bus.redirect_target = 32'hFFFF_FFFC;
    step();
    chk("top_pc", bus.pc, 32'hFFFF_FFFC);
    chk("top_inc", bus.pc_plus_inc, 32'h0);
    clr();
    step();
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_inc", bus.pc_plus_inc, 32'h4);

    bus.redirect_valid = 1; bus.redirect_target = 32'h50;
    step(); chk("redir50", bus.pc, 32'h50);
    clr(); bus.halt_req = 1;
    step();
    chk("halt_state", 32'(bus.state), 32'd2);
    chk("halt_valid", 32'(bus.pc_valid), 32'd0);
    chk("halt_pc", bus.pc, 32'h50);
    clr(); bus.trap_req = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_hold_pc", bus.pc, 32'h50);
      chk("halt_hold_state", 32'(bus.state), 32'd2);
    end
    chk("halt_epc", bus.epc, 32'h30);
    clr(); bus.resume = 1;
    step();
    chk("resume_state", 32'(bus.state), 32'd1);
    chk("resume_pc", bus.pc, 32'h50);
    clr();
    step(); chk("resume_seq", bus.pc, 32'h54);

    bus.halt_req = 1;
    step(); chk("halt2_state", 32'(bus.state), 32'd2);
    clr(); bus.trap_req = 1;
    #2 reset = 1'b0;
    #1;
    chk("areset_pc", bus.pc, 32'h0);
    chk("areset_state", 32'(bus.state), 32'd0);
    chk("areset_epc", bus.epc, 32'h0);
    chk("areset_valid", 32'(bus.pc_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
